// File: rtl/fir_flow_ctrl.sv
// Flow-control sequencer around a fixed-latency FIR: credit-bounded input issue,
// output FIFO, zero-injection flush and response monitoring. Optional stats: FIR_FLOW_CTRL_STATS_EN.
module fir_flow_ctrl #(
  parameter int unsigned INPUT_WIDTH  = 16,
  parameter int unsigned OUTPUT_WIDTH = 33,
  parameter int unsigned NUM_TAPS     = 40,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned RESP_TIMEOUT = 100
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [INPUT_WIDTH-1:0]  s_data,
  output logic                    fir_in_valid,
  output logic [INPUT_WIDTH-1:0]  fir_in_data,
  input  logic                    fir_out_valid,
  input  logic [OUTPUT_WIDTH-1:0] fir_out_data,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [OUTPUT_WIDTH-1:0] m_data,
  input  logic                    flush_req,
  output logic                    busy,
  output logic                    flush_done,
  output logic                    err_timeout,
  output logic                    err_unexpected
`ifdef FIR_FLOW_CTRL_STATS_EN
  ,
  output logic [31:0]             stat_in_cnt,
  output logic [31:0]             stat_out_cnt,
  output logic [31:0]             stat_stall_cnt
`endif
);

  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW  = OCW + 1;
  localparam int unsigned DW  = $clog2(NUM_TAPS + 1);
  localparam int unsigned FW  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam int unsigned TW  = $clog2(RESP_TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_e;

  state_e                  state_q, state_d;
  logic [OCW-1:0]          keep_q, keep_d;
  logic [DW-1:0]           disc_q, disc_d;
  logic [OCW-1:0]          occ_q, occ_d;
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]           tap_q, tap_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    in_valid_q, in_valid_d;
  logic [INPUT_WIDTH-1:0]  in_data_q, in_data_d;
  logic                    done_q, done_d;
  logic                    err_to_q, err_to_d;
  logic                    err_ux_q, err_ux_d;
  logic                    live_q;
  logic [OUTPUT_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic credit_ok, ready_w, hs, push, pop, drop_disc, unexp, inflight, timed_out;
  logic issue_zero, clear_cnt;

  // Kept results need a FIFO slot reserved from issue until pop; discards need none.
  assign credit_ok  = (SW'(occ_q) + SW'(keep_q)) < SW'(FIFO_DEPTH);
  assign ready_w    = live_q && (state_q == ST_RUN) && credit_ok;
  assign hs         = s_valid && ready_w;
  assign push       = fir_out_valid && (keep_q != '0);
  assign drop_disc  = fir_out_valid && (keep_q == '0) && (disc_q != '0);
  assign unexp      = fir_out_valid && (keep_q == '0) && (disc_q == '0);
  assign pop        = (occ_q != '0) && m_ready;
  assign inflight   = (keep_q != '0) || (disc_q != '0);
  assign timed_out  = (timer_q == TW'(RESP_TIMEOUT));
  assign issue_zero = (state_q == ST_FLUSH);

  always_comb begin
    state_d    = state_q;
    tap_d      = tap_q;
    in_valid_d = 1'b0;
    in_data_d  = in_data_q;
    done_d     = 1'b0;
    clear_cnt  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (hs) begin
          in_valid_d = 1'b1;
          in_data_d  = s_data;
        end
        if (flush_req) begin
          state_d = ST_FLUSH;
          tap_d   = '0;
        end
      end
      ST_FLUSH: begin
        in_valid_d = 1'b1;
        in_data_d  = '0;
        tap_d      = tap_q + FW'(1);
        if (tap_q == FW'(NUM_TAPS - 1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        // A dead filter must not wedge the block: the timeout also ends the drain.
        if (!inflight || timed_out) begin
          state_d   = ST_RUN;
          done_d    = 1'b1;
          clear_cnt = 1'b1;
        end
      end
      default: state_d = ST_RUN;
    endcase

    keep_d = keep_q + OCW'(hs) - OCW'(push);
    disc_d = disc_q + DW'(issue_zero) - DW'(drop_disc);
    if (clear_cnt) begin
      keep_d = '0;
      disc_d = '0;
    end

    occ_d    = occ_q + OCW'(push) - OCW'(pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

    timer_d = timer_q;
    if (!inflight || fir_out_valid) timer_d = '0;
    else if (!timed_out)            timer_d = timer_q + TW'(1);

    err_to_d = err_to_q || (timer_d == TW'(RESP_TIMEOUT));
    err_ux_d = err_ux_q || unexp;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      keep_q     <= '0;
      disc_q     <= '0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tap_q      <= '0;
      timer_q    <= '0;
      in_valid_q <= 1'b0;
      in_data_q  <= '0;
      done_q     <= 1'b0;
      err_to_q   <= 1'b0;
      err_ux_q   <= 1'b0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      keep_q     <= keep_d;
      disc_q     <= disc_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tap_q      <= tap_d;
      timer_q    <= timer_d;
      in_valid_q <= in_valid_d;
      in_data_q  <= in_data_d;
      done_q     <= done_d;
      err_to_q   <= err_to_d;
      err_ux_q   <= err_ux_d;
      live_q     <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= fir_out_data;
    end
  end

  assign s_ready        = ready_w;
  assign fir_in_valid   = in_valid_q;
  assign fir_in_data    = in_data_q;
  assign m_valid        = (occ_q != '0);
  assign m_data         = mem_q[rd_ptr_q];
  assign busy           = (state_q == ST_FLUSH) || (state_q == ST_DRAIN);
  assign flush_done     = done_q;
  assign err_timeout    = err_to_q;
  assign err_unexpected = err_ux_q;

`ifdef FIR_FLOW_CTRL_STATS_EN
  logic [31:0] st_in_q, st_out_q, st_stall_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_in_q    <= '0;
      st_out_q   <= '0;
      st_stall_q <= '0;
    end else begin
      if (hs)  st_in_q  <= st_in_q + 32'd1;
      if (pop) st_out_q <= st_out_q + 32'd1;
      if (s_valid && !ready_w && (state_q == ST_RUN)) st_stall_q <= st_stall_q + 32'd1;
    end
  end

  assign stat_in_cnt    = st_in_q;
  assign stat_out_cnt   = st_out_q;
  assign stat_stall_cnt = st_stall_q;
`endif

endmodule

// File: tb/tb_fir_flow_ctrl.sv
// Bench for fir_flow_ctrl: echo-filter model, accepted-sample scoreboard and directed scenarios.
module tb_fir_flow_ctrl;
  localparam int IW = 16, OW = 33, DEPTH = 16, TAPS = 40, TMO = 100, LAT = 8;

  logic          clk = 1'b0, reset_n = 1'b1;
  logic          s_valid = 1'b0, s_ready;
  logic [IW-1:0] s_data = '0;
  logic          fir_in_valid;
  logic [IW-1:0] fir_in_data;
  logic          fir_out_valid = 1'b0;
  logic [OW-1:0] fir_out_data = '0;
  logic          m_valid, m_ready = 1'b0;
  logic [OW-1:0] m_data;
  logic          flush_req = 1'b0, busy, flush_done, err_timeout, err_unexpected;
`ifdef FIR_FLOW_CTRL_STATS_EN
  logic [31:0]   stat_in_cnt, stat_out_cnt, stat_stall_cnt;
`endif

  fir_flow_ctrl #(
    .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .NUM_TAPS(TAPS),
    .FIFO_DEPTH(DEPTH), .RESP_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fir_in_valid(fir_in_valid), .fir_in_data(fir_in_data),
    .fir_out_valid(fir_out_valid), .fir_out_data(fir_out_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .flush_req(flush_req), .busy(busy), .flush_done(flush_done),
    .err_timeout(err_timeout), .err_unexpected(err_unexpected)
`ifdef FIR_FLOW_CTRL_STATS_EN
    , .stat_in_cnt(stat_in_cnt), .stat_out_cnt(stat_out_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0, cyc = 0;
  always @(posedge clk) cyc++;

  // Filter model: LAT-cycle echo of the input sample, plus a manual injection hook.
  logic          pv [LAT];
  logic [IW-1:0] pd [LAT];
  logic          filt_en = 1'b1, inj = 1'b0;
  logic [OW-1:0] inj_data = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin pv[i] = 1'b0; pd[i] = '0; end
      fir_out_valid = 1'b0;
      fir_out_data  = '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin pv[i] = pv[i-1]; pd[i] = pd[i-1]; end
      pv[0] = fir_in_valid;
      pd[0] = fir_in_data;
      fir_out_valid = (filt_en && pv[LAT-1]) || inj;
      fir_out_data  = inj ? inj_data : OW'(pd[LAT-1]);
    end
  end

  // Scoreboard: every accepted sample must come out once, in order, and the
  // number accepted-but-not-delivered bounds upstream readiness.
  logic [OW-1:0] exp_q[$], got_q[$];
  logic          chk_en = 1'b0;
  int            zero_pulses = 0, fd_cnt = 0, t_in = -1, t_err = -1;
  always @(negedge clk) begin
    if (chk_en) begin
      logic want_rdy;
      logic [OW-1:0] want;
      want_rdy = !busy && (exp_q.size() < DEPTH);
      n_cmp++;
      if (s_ready !== want_rdy) begin
        n_err++;
        $display("FAIL s_ready_model @%0d: got %b want %b", cyc, s_ready, want_rdy);
      end
      if (m_valid && m_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL m_data_extra @%0d: got %0h want nothing", cyc, m_data);
        end else begin
          want = exp_q.pop_front();
          if (m_data !== want) begin
            n_err++;
            $display("FAIL m_data_order @%0d: got %0h want %0h", cyc, m_data, want);
          end
          got_q.push_back(m_data);
        end
      end
      if (s_valid && s_ready) exp_q.push_back(OW'(s_data));
      if (fir_in_valid && fir_in_data == '0) zero_pulses++;
      if (flush_done) fd_cnt++;
      if (fir_in_valid && t_in < 0) t_in = cyc;
      if (err_timeout && t_err < 0) t_err = cyc;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic do_reset;
    chk_en = 1'b0;
    reset_n = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; flush_req = 1'b0;
    inj = 1'b0; filt_en = 1'b1;
    repeat (3) tick;
    reset_n = 1'b1;
    repeat (2) tick;
    exp_q.delete(); got_q.delete();
    zero_pulses = 0; fd_cnt = 0; t_in = -1; t_err = -1;
    chk_en = 1'b1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || m_valid) && n < budget) begin tick; n++; end
    n_cmp++;
    if (exp_q.size() != 0 || m_valid) begin
      n_err++;
      $display("FAIL %s: %0d results outstanding after %0d cycles, want 0", name, exp_q.size(), n);
    end
  endtask

  initial begin
    int hs, n;
    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("reset_outputs",
          {s_ready, fir_in_valid, fir_in_data, m_valid, m_data, busy, flush_done, err_timeout, err_unexpected},
          '0);
    do_reset;
    check("ready_after_reset", s_ready, 1'b1);

    // Passthrough
    m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      s_data = IW'(i); s_valid = 1'b1;
      check("pt_ready", s_ready, 1'b1);
      tick;
    end
    s_valid = 1'b0;
    wait_idle("pt_drain", 60);
    check("pt_count", got_q.size(), 5);
    for (int k = 0; k < 5 && k < got_q.size(); k++) check("pt_data", got_q[k], 64'(k + 1));
    check("pt_errors", {err_timeout, err_unexpected}, 2'b00);

    // Backpressure
    got_q.delete();
    m_ready = 1'b0; s_valid = 1'b1; hs = 0;
    repeat (40) begin
      s_data = IW'(100 + hs);
      if (s_ready) hs++;
      tick;
    end
    s_valid = 1'b0;
    check("bp_handshakes", hs, 16);
    check("bp_ready_low", s_ready, 1'b0);
    check("bp_m_valid", m_valid, 1'b1);
    m_ready = 1'b1;
    wait_idle("bp_drain", 80);
    check("bp_count", got_q.size(), 16);
    if (got_q.size() == 16) begin
      check("bp_first", got_q[0], 64'd100);
      check("bp_last", got_q[15], 64'd115);
    end

    // Flush with 3 samples in flight; upstream keeps offering during the flush
    got_q.delete(); zero_pulses = 0; fd_cnt = 0;
    for (int v = 7; v <= 9; v++) begin s_data = IW'(v); s_valid = 1'b1; tick; end
    s_valid = 1'b0;
    flush_req = 1'b1; tick; flush_req = 1'b0;
    check("fl_busy", busy, 1'b1);
    check("fl_ready", s_ready, 1'b0);
    s_data = IW'(55); s_valid = 1'b1;
    n = 0;
    while (!flush_done && n < 300) begin tick; n++; end
    s_valid = 1'b0;
    check("fl_done_seen", flush_done, 1'b1);
    wait_idle("fl_drain", 40);
    repeat (3) tick;
    check("fl_done_pulses", fd_cnt, 1);
    check("fl_zero_pulses", zero_pulses, 40);
    check("fl_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      check("fl_d0", got_q[0], 64'd7);
      check("fl_d1", got_q[1], 64'd8);
      check("fl_d2", got_q[2], 64'd9);
    end
    check("fl_idle", busy, 1'b0);
    check("fl_errors", {err_timeout, err_unexpected}, 2'b00);

    // Timeout: filter never answers
    do_reset;
    filt_en = 1'b0; m_ready = 1'b1;
    s_data = IW'(5); s_valid = 1'b1; tick; s_valid = 1'b0;
    n = 0;
    while (!err_timeout && n < 300) begin tick; n++; end
    repeat (20) tick;
    check("to_latency", t_err - t_in, 100);
    check("to_sticky", err_timeout, 1'b1);
    check("to_no_unexp", err_unexpected, 1'b0);
    do_reset;
    check("to_cleared", err_timeout, 1'b0);

    // Unexpected output with nothing in flight
    inj_data = 33'h0_0000_BEEF;
    inj = 1'b1; tick; inj = 1'b0;
    repeat (4) begin check("ux_m_valid", m_valid, 1'b0); tick; end
    check("ux_flag", err_unexpected, 1'b1);
    check("ux_no_timeout", err_timeout, 1'b0);

    // Reset in the middle of a flush
    do_reset;
    m_ready = 1'b1;
    for (int v = 3; v <= 4; v++) begin s_data = IW'(v); s_valid = 1'b1; tick; end
    s_valid = 1'b0;
    flush_req = 1'b1; tick; flush_req = 1'b0;
    repeat (5) tick;
    check("rf_in_flush", {busy, fir_in_valid}, 2'b11);
    chk_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check("rf_outputs",
          {s_ready, fir_in_valid, fir_in_data, m_valid, m_data, busy, flush_done, err_timeout, err_unexpected},
          '0);
    repeat (2) tick;
    reset_n = 1'b1;
    repeat (2) tick;
    check("rf_ready", {s_ready, busy}, 2'b10);

    // Normal traffic resumes after reset
    do_reset;
    m_ready = 1'b1;
    s_data = IW'(16'h0042); s_valid = 1'b1; tick; s_valid = 1'b0;
    wait_idle("post_drain", 40);
    check("post_count", got_q.size(), 1);
    if (got_q.size() == 1) check("post_data", got_q[0], 64'h42);
    check("post_errors", {err_timeout, err_unexpected}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
